uart_alu_intf: RTL and testbench

//  Sequencer between UART RX/TX and the ALU inside top. Collects three RX bytes (operand A, operand B, opcode),

---
 rtl/uart_alu_intf_pkg.sv | 30 +++
 rtl/uart_alu_intf_if.sv | 50 +++++
 rtl/uart_alu_intf_timer.sv | 38 +++
 rtl/uart_alu_intf.sv | 125 ++++++++++++
 tb/tb_uart_alu_intf.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_alu_intf_pkg.sv
// Shared definitions for the UART <-> ALU sequencer: opcodes, FSM states and sizing helpers.
package uart_alu_intf_pkg;

    localparam int unsigned NbDataDef = 8;
    localparam int unsigned NbOpDef   = 6;

    localparam logic [5:0] OpAdd = 6'b100000;
    localparam logic [5:0] OpSub = 6'b100010;
    localparam logic [5:0] OpAnd = 6'b100100;
    localparam logic [5:0] OpOr  = 6'b100101;
    localparam logic [5:0] OpXor = 6'b100110;
    localparam logic [5:0] OpNor = 6'b100111;
    localparam logic [5:0] OpSra = 6'b000011;
    localparam logic [5:0] OpSrl = 6'b000010;

    typedef enum logic [2:0] {
        StGetA,
        StGetB,
        StGetOp,
        StCalc,
        StSend,
        StWaitTx
    } state_e;

    // A zero cycle count disables the timer, but the counter still needs one bit.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/uart_alu_intf_if.sv
// Bundle of RX/TX/ALU handshake signals between the sequencer (master) and its surroundings (slave).
interface uart_alu_intf_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) ();

    logic               rx_to_intf_done;
    logic [NB_DATA-1:0] rx_to_intf_data;
    logic               tx_to_intf_active;
    logic               tx_to_intf_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic               tx_start;
    logic [NB_DATA-1:0] intf_to_tx_result;
    logic               o_timeout;
    logic               o_overrun;

    modport master (
        input  rx_to_intf_done,
        input  rx_to_intf_data,
        input  tx_to_intf_active,
        input  tx_to_intf_done,
        input  i_alu_result,
        output o_alu_a,
        output o_alu_b,
        output o_alu_op,
        output tx_start,
        output intf_to_tx_result,
        output o_timeout,
        output o_overrun
    );

    modport slave (
        output rx_to_intf_done,
        output rx_to_intf_data,
        output tx_to_intf_active,
        output tx_to_intf_done,
        output i_alu_result,
        input  o_alu_a,
        input  o_alu_b,
        input  o_alu_op,
        input  tx_start,
        input  intf_to_tx_result,
        input  o_timeout,
        input  o_overrun
    );

endinterface

// File: rtl/uart_alu_intf_timer.sv
// Inter-byte idle timer: counts while enabled, restarts on clear or when disabled,
// and flags expiry on the last allowed idle cycle.
module uart_alu_intf_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned CntWidth       = 20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned   LastVal = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(LastVal);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (!expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_intf.sv
// Collects A, B and opcode bytes from UART RX, feeds them registered to the ALU, and sends
// the ALU result back on UART TX. Guards a frame with an inter-byte timeout.
module uart_alu_intf
    import uart_alu_intf_pkg::*;
#(
    parameter int unsigned NB_DATA        = NbDataDef,
    parameter int unsigned NB_OP          = NbOpDef,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              i_Clock,
    input  logic              i_reset,
    uart_alu_intf_if.master   bus
);

    localparam int unsigned CntWidth = timer_width(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [NB_DATA-1:0] res_q, res_d;
    logic               tx_start;
    logic               timeout;
    logic               overrun;
    logic               tmr_clr;
    logic               tmr_en;
    logic               tmr_expire;

    uart_alu_intf_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CntWidth       (CntWidth)
    ) u_timer (
        .clk_i    (i_Clock),
        .rst_ni   (i_reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expire_o (tmr_expire)
    );

    assign tmr_en = (state_q == StGetB) || (state_q == StGetOp);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        res_d    = res_q;
        tx_start = 1'b0;
        timeout  = 1'b0;
        overrun  = 1'b0;
        tmr_clr  = 1'b0;
        unique case (state_q)
            StGetA: begin
                if (bus.rx_to_intf_done) begin
                    a_d     = bus.rx_to_intf_data;
                    state_d = StGetB;
                end
            end
            // An arriving byte takes priority over a coincident expiry.
            StGetB: begin
                if (bus.rx_to_intf_done) begin
                    b_d     = bus.rx_to_intf_data;
                    tmr_clr = 1'b1;
                    state_d = StGetOp;
                end else if (tmr_expire) begin
                    timeout = 1'b1;
                    state_d = StGetA;
                end
            end
            StGetOp: begin
                if (bus.rx_to_intf_done) begin
                    op_d    = bus.rx_to_intf_data[NB_OP-1:0];
                    state_d = StCalc;
                end else if (tmr_expire) begin
                    timeout = 1'b1;
                    state_d = StGetA;
                end
            end
            StCalc: begin
                overrun = bus.rx_to_intf_done;
                res_d   = bus.i_alu_result;
                state_d = StSend;
            end
            StSend: begin
                overrun = bus.rx_to_intf_done;
                if (!bus.tx_to_intf_active) begin
                    tx_start = 1'b1;
                    state_d  = StWaitTx;
                end
            end
            StWaitTx: begin
                overrun = bus.rx_to_intf_done;
                if (bus.tx_to_intf_done) begin
                    state_d = StGetA;
                end
            end
            default: state_d = StGetA;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StGetA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
        end
    end

    assign bus.o_alu_a           = a_q;
    assign bus.o_alu_b           = b_q;
    assign bus.o_alu_op          = op_q;
    assign bus.intf_to_tx_result = res_q;
    assign bus.tx_start          = tx_start;
    assign bus.o_timeout         = timeout;
    assign bus.o_overrun         = overrun;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Bench for uart_alu_intf: behavioural ALU and TX models, frame vectors, random frames and
// hand-written timeout / overrun / reset / TX-busy sequences.
module tb_uart_alu_intf;
    import uart_alu_intf_pkg::*;

    localparam int unsigned TO = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    uart_alu_intf_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    uart_alu_intf #(
        .NB_DATA        (8),
        .NB_OP          (6),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_Clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    logic model_active = 1'b0;
    logic model_done   = 1'b0;
    logic model_busy   = 1'b0;
    logic force_active = 1'b0;
    logic manual_done  = 1'b0;
    int unsigned tx_len = 8;
    logic [7:0] got_q[$];
    int n_cmp = 0, n_err = 0, n_start = 0, n_to = 0, n_ovr = 0, exp_start = 0;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        logic signed [7:0] sa;
        sa = a;
        case (op)
            OpAdd:   return 8'(a + b);
            OpSub:   return 8'(a - b);
            OpAnd:   return a & b;
            OpOr:    return a | b;
            OpXor:   return a ^ b;
            OpNor:   return ~(a | b);
            OpSra:   return 8'(sa >>> b);
            OpSrl:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.i_alu_result      = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
    assign bus.tx_to_intf_active = model_active | force_active;
    assign bus.tx_to_intf_done   = model_done | manual_done;

    // TX model: busy for tx_len cycles after each start, then a done pulse.
    initial forever begin
        @(negedge clk);
        if (bus.tx_start === 1'b1) begin
            got_q.push_back(bus.intf_to_tx_result);
            model_busy = 1'b1;
            @(posedge clk);
            #1 model_active = 1'b1;
            repeat (tx_len) @(posedge clk);
            #1 model_active = 1'b0;
            model_done = 1'b1;
            @(posedge clk);
            #1 model_done = 1'b0;
            model_busy = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (bus.tx_start === 1'b1)  n_start++;
        if (bus.o_timeout === 1'b1) n_to++;
        if (bus.o_overrun === 1'b1) n_ovr++;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "bench time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] x);
        bus.rx_to_intf_data = x;
        bus.rx_to_intf_done = 1'b1;
        tick();
        bus.rx_to_intf_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                              input int gap);
        send_byte(a);
        repeat (gap) tick();
        send_byte(b);
        repeat (gap) tick();
        send_byte(opb);
        exp_start++;
    endtask

    task automatic wait_busy();
        int k = 0;
        while (!model_busy && k < 200) begin
            tick();
            k++;
        end
    endtask

    task automatic collect(input string name, input logic [7:0] exp);
        int k = 0;
        while (got_q.size() == 0 && k < 200) begin
            tick();
            k++;
        end
        check({name, "_txcount"}, got_q.size(), 1);
        if (got_q.size() > 0) check(name, got_q.pop_front(), exp);
        k = 0;
        while (model_busy && k < 200) begin
            tick();
            k++;
        end
        check({name, "_txidle"}, model_busy, 0);
        tick();
        check({name, "_starts"}, n_start, exp_start);
    endtask

    task automatic check_zero(input string name);
        check({name, "_a"}, bus.o_alu_a, 0);
        check({name, "_b"}, bus.o_alu_b, 0);
        check({name, "_op"}, bus.o_alu_op, 0);
        check({name, "_res"}, bus.intf_to_tx_result, 0);
        check({name, "_start"}, bus.tx_start, 0);
        check({name, "_tmo"}, bus.o_timeout, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] op;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[$];
    logic [5:0] ops[8];
    int to0, ovr0, s0;

    initial begin
        bus.rx_to_intf_done = 1'b0;
        bus.rx_to_intf_data = 8'h00;
        ops = '{OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl};
        vecs.push_back('{8'd22,  8'd18,  8'h20, 6'h20, 8'd40});
        vecs.push_back('{8'd22,  8'd18,  8'h22, 6'h22, 8'd4});
        vecs.push_back('{8'h0F,  8'hF0,  8'h25, 6'h25, 8'hFF});
        vecs.push_back('{8'hF0,  8'h3C,  8'h24, 6'h24, 8'h30});
        vecs.push_back('{8'hF0,  8'h3C,  8'h26, 6'h26, 8'hCC});
        vecs.push_back('{8'h0A,  8'h50,  8'h27, 6'h27, 8'hA5});
        vecs.push_back('{8'h80,  8'd3,   8'h03, 6'h03, 8'hF0});
        vecs.push_back('{8'h80,  8'd3,   8'h02, 6'h02, 8'h10});
        vecs.push_back('{8'd5,   8'd6,   8'hE0, 6'h20, 8'd11});
        vecs.push_back('{8'hFF,  8'h01,  8'h20, 6'h20, 8'h00});
        vecs.push_back('{8'h00,  8'h01,  8'h22, 6'h22, 8'hFF});
        vecs.push_back('{8'h12,  8'h34,  8'h3F, 6'h3F, 8'h00});

        #50;
        check_zero("reset");
        check("reset_ovr", bus.o_overrun, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].a, vecs[i].b, vecs[i].opb, i % 3);
            collect($sformatf("vec%0d", i), vecs[i].res);
            check($sformatf("vec%0d_a", i), bus.o_alu_a, vecs[i].a);
            check($sformatf("vec%0d_b", i), bus.o_alu_b, vecs[i].b);
            check($sformatf("vec%0d_op", i), bus.o_alu_op, vecs[i].op);
        end

        // Latency: opcode sampled at edge N -> op visible after N, tx_start after N+1.
        send_byte(8'd9);
        send_byte(8'd7);
        bus.rx_to_intf_data = 8'h20;
        bus.rx_to_intf_done = 1'b1;
        @(posedge clk);
        #1 bus.rx_to_intf_done = 1'b0;
        @(negedge clk);
        check("lat_op", bus.o_alu_op, 6'h20);
        check("lat_nostart", bus.tx_start, 0);
        @(negedge clk);
        check("lat_start", bus.tx_start, 1);
        check("lat_res", bus.intf_to_tx_result, 8'd16);
        exp_start++;
        collect("lat", 8'd16);

        // Timeout in GET_B fires exactly on the TO-th idle cycle.
        to0 = n_to;
        send_byte(8'h05);
        repeat (TO - 2) @(posedge clk);
        @(negedge clk);
        check("tmo_early", bus.o_timeout, 0);
        @(posedge clk);
        @(negedge clk);
        check("tmo_edge", bus.o_timeout, 1);
        check("tmo_a", bus.o_alu_a, 8'h05);
        tick();
        repeat (TO + 100) tick();
        check("tmo_once", n_to, to0 + 1);
        send_frame(8'd3, 8'd4, 8'h20, 0);
        collect("tmo_next", 8'd7);

        // Byte arriving on the expiry cycle is accepted.
        to0 = n_to;
        send_byte(8'h11);
        repeat (TO - 1) @(posedge clk);
        #1 bus.rx_to_intf_data = 8'h22;
        bus.rx_to_intf_done = 1'b1;
        @(negedge clk);
        check("win_notmo", bus.o_timeout, 0);
        @(posedge clk);
        #1 bus.rx_to_intf_done = 1'b0;
        check("win_b", bus.o_alu_b, 8'h22);
        send_byte(8'h20);
        exp_start++;
        collect("win", 8'h33);
        check("win_tocount", n_to, to0);

        // Timeout in GET_OP keeps the operand registers.
        to0 = n_to;
        send_byte(8'd1);
        send_byte(8'd2);
        repeat (TO + 10) tick();
        check("tmo_op_count", n_to, to0 + 1);
        check("tmo_op_b", bus.o_alu_b, 8'd2);
        check("tmo_op_op", bus.o_alu_op, 6'h20);

        // Overrun: byte during WAIT_TX is dropped.
        ovr0 = n_ovr;
        send_frame(8'h30, 8'h05, 8'h22, 0);
        wait_busy();
        repeat (2) tick();
        send_byte(8'hAA);
        collect("ovr", 8'h2B);
        check("ovr_count", n_ovr, ovr0 + 1);
        check("ovr_a", bus.o_alu_a, 8'h30);
        send_frame(8'h40, 8'h02, 8'h02, 1);
        collect("ovr_next", 8'h10);

        // tx done outside WAIT_TX is ignored.
        send_byte(8'h07);
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        send_byte(8'h08);
        send_byte(8'h20);
        exp_start++;
        collect("stray_done", 8'd15);

        // TX busy holds off tx_start; a stray done in SEND does nothing.
        force_active = 1'b1;
        s0 = n_start;
        send_frame(8'h10, 8'h20, 8'h20, 0);
        repeat (15) tick();
        check("hold_nostart", n_start, s0);
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        repeat (3) tick();
        check("hold_nostart2", n_start, s0);
        force_active = 1'b0;
        collect("hold", 8'h30);

        // Reset while in GET_OP.
        send_byte(8'h55);
        send_byte(8'h66);
        #8 rst_n = 1'b0;
        #2 check_zero("rst_op");
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'd1, 8'd1, 8'h20, 0);
        collect("rst_op_next", 8'd2);

        // Reset while in WAIT_TX.
        send_frame(8'h09, 8'h09, 8'h20, 0);
        wait_busy();
        repeat (2) tick();
        #5 rst_n = 1'b0;
        #2 check_zero("rst_tx");
        while (model_busy) tick();
        rst_n = 1'b1;
        tick();
        got_q.delete();
        send_frame(8'd1, 8'd1, 8'h20, 0);
        collect("rst_tx_next", 8'd2);

        // Random frames against the behavioural ALU.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] a, b, opb;
            logic [5:0] op;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            opb = {2'($urandom), op};
            tx_len = $urandom_range(1, 12);
            send_frame(a, b, opb, $urandom_range(0, 4));
            collect($sformatf("rnd%0d", i), alu_ref(a, b, op));
            check($sformatf("rnd%0d_op", i), bus.o_alu_op, op);
            check($sformatf("rnd%0d_a", i), bus.o_alu_a, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
